// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite move controller.
package sprite_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_LOAD,
    ST_DRAW,
    ST_DONE
  } state_e;

  // Unsigned 8-bit min, keeps the sprite's far edge on screen.
  function automatic logic [7:0] clamp8(input logic [7:0] v, input logic [7:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/pixel_scan_counter.sv
// Raster scan of a SIZE x SIZE block: dx fastest, dy slowest, wraps to (0,0) after the last pixel.
module pixel_scan_counter #(
  parameter int SIZE = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  output logic [3:0] dx,
  output logic [3:0] dy,
  output logic       last
);

  localparam logic [3:0] LAST_IDX = 4'(SIZE - 1);

  logic [3:0] dx_q;
  logic [3:0] dy_q;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      dx_q <= '0;
      dy_q <= '0;
    end else if (enable) begin
      if (dx_q == LAST_IDX) begin
        dx_q <= '0;
        dy_q <= (dy_q == LAST_IDX) ? 4'd0 : dy_q + 4'd1;
      end else begin
        dx_q <= dx_q + 4'd1;
      end
    end
  end

  assign dx   = dx_q;
  assign dy   = dy_q;
  assign last = (dx_q == LAST_IDX) && (dy_q == LAST_IDX);

endmodule

// File: rtl/sprite_draw_ctrl.sv
// Sprite move controller: erases the old square (if drawn), loads the clamped
// new position and colour, redraws, then pulses done.
module sprite_draw_ctrl
  import sprite_pkg::*;
#(
  parameter int SIZE     = 16,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
  input  logic [7:0] new_x,
  input  logic [6:0] new_y,
  input  logic [5:0] color_in,
  output logic       ready,
  output logic [7:0] x0,
  output logic [6:0] y0,
  output logic [3:0] dx,
  output logic [3:0] dy,
  output logic [5:0] color,
  output logic       undraw,
  output logic       plot,
  output logic       done
);

  localparam logic [7:0] X_LIM = 8'(SCREEN_W - SIZE);
  localparam logic [7:0] Y_LIM = 8'(SCREEN_H - SIZE);

  state_e     state_q;
  logic       ready_q, plot_q, undraw_q, done_q, drawn_q;
  logic [7:0] x0_q, pend_x_q;
  logic [6:0] y0_q, pend_y_q;
  logic [5:0] color_q, pend_color_q;

  logic scan_en;
  logic scan_last;

  assign scan_en = (state_q == ST_ERASE) || (state_q == ST_DRAW);

  pixel_scan_counter #(.SIZE(SIZE)) u_scan (
    .clock  (clock),
    .reset  (reset),
    .clear  (!scan_en),
    .enable (scan_en),
    .dx     (dx),
    .dy     (dy),
    .last   (scan_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b1;
      plot_q       <= 1'b0;
      undraw_q     <= 1'b0;
      done_q       <= 1'b0;
      drawn_q      <= 1'b0;
      x0_q         <= '0;
      y0_q         <= '0;
      color_q      <= '0;
      pend_x_q     <= '0;
      pend_y_q     <= '0;
      pend_color_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            pend_x_q     <= clamp8(new_x, X_LIM);
            pend_y_q     <= 7'(clamp8({1'b0, new_y}, Y_LIM));
            pend_color_q <= color_in;
            ready_q      <= 1'b0;
            // Nothing on screen yet means there is nothing to erase.
            state_q      <= drawn_q ? ST_ERASE : ST_LOAD;
            plot_q       <= drawn_q;
            undraw_q     <= drawn_q;
          end
        end
        ST_ERASE: begin
          if (scan_last) begin
            state_q  <= ST_LOAD;
            plot_q   <= 1'b0;
            undraw_q <= 1'b0;
          end
        end
        ST_LOAD: begin
          x0_q    <= pend_x_q;
          y0_q    <= pend_y_q;
          color_q <= pend_color_q;
          plot_q  <= 1'b1;
          state_q <= ST_DRAW;
        end
        ST_DRAW: begin
          if (scan_last) begin
            drawn_q <= 1'b1;
            plot_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q  <= ST_IDLE;
          ready_q  <= 1'b1;
          plot_q   <= 1'b0;
          undraw_q <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ready  = ready_q;
  assign plot   = plot_q;
  assign undraw = undraw_q;
  assign done   = done_q;
  assign x0     = x0_q;
  assign y0     = y0_q;
  assign color  = color_q;

endmodule

// File: tb/tb_sprite_draw_ctrl.sv
// Directed bench for sprite_draw_ctrl: SIZE=16 instance for the main moves,
// a SIZE=4 instance for scan-order checking on a small sprite.
module tb_sprite_draw_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       go = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] nx = '0;
  logic [6:0] ny = '0;
  logic [5:0] ncol = '0;

  logic       rdy_a, und_a, plt_a, dn_a, rdy_b, und_b, plt_b, dn_b;
  logic [7:0] x0_a, x0_b;
  logic [6:0] y0_a, y0_b;
  logic [3:0] dx_a, dy_a, dx_b, dy_b;
  logic [5:0] col_a, col_b;

  sprite_draw_ctrl u_dut (
    .clock(clk), .reset(rst), .go(go & ~sel), .new_x(nx), .new_y(ny), .color_in(ncol),
    .ready(rdy_a), .x0(x0_a), .y0(y0_a), .dx(dx_a), .dy(dy_a), .color(col_a),
    .undraw(und_a), .plot(plt_a), .done(dn_a)
  );

  sprite_draw_ctrl #(.SIZE(4)) u_dut4 (
    .clock(clk), .reset(rst), .go(go & sel), .new_x(nx), .new_y(ny), .color_in(ncol),
    .ready(rdy_b), .x0(x0_b), .y0(y0_b), .dx(dx_b), .dy(dy_b), .color(col_b),
    .undraw(und_b), .plot(plt_b), .done(dn_b)
  );

  logic       rdy, und, plt, dn;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [3:0] dx, dy;
  logic [5:0] col;
  assign rdy = sel ? rdy_b : rdy_a;
  assign und = sel ? und_b : und_a;
  assign plt = sel ? plt_b : plt_a;
  assign dn  = sel ? dn_b  : dn_a;
  assign x0  = sel ? x0_b  : x0_a;
  assign y0  = sel ? y0_b  : y0_a;
  assign dx  = sel ? dx_b  : dx_a;
  assign dy  = sel ? dy_b  : dy_a;
  assign col = sel ? col_b : col_a;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".ready"},  int'(rdy), 1);
    chk({tag, ".plot"},   int'(plt), 0);
    chk({tag, ".undraw"}, int'(und), 0);
    chk({tag, ".done"},   int'(dn),  0);
    chk({tag, ".x0"},     int'(x0),  0);
    chk({tag, ".y0"},     int'(y0),  0);
    chk({tag, ".dx"},     int'(dx),  0);
    chk({tag, ".dy"},     int'(dy),  0);
    chk({tag, ".color"},  int'(col), 0);
  endtask

  // One move: go is accepted at the posedge ending cycle 0, cycle k is sampled
  // at the k-th following negedge.
  task automatic do_move(input string tag, input int ix, input int iy, input int icol,
                         input bit hold, input int size, input bit exp_erase,
                         input int ox, input int oy, input int ex, input int ey,
                         input int exp_done);
    int s, n_er, n_dr, first_dr, done_cyc, pos_err, ord_err, rdy_err, mx, my;
    s = size * size;
    n_er = 0; n_dr = 0; first_dr = -1; done_cyc = -1;
    pos_err = 0; ord_err = 0; rdy_err = 0; mx = 0; my = 0;
    @(negedge clk);
    chk({tag, ".ready_before"}, int'(rdy), 1);
    nx = 8'(ix); ny = 7'(iy); ncol = 6'(icol); go = 1'b1;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (!hold) go = 1'b0;
      if (rdy) rdy_err++;
      if (plt && und) begin
        if (int'(x0) != ox || int'(y0) != oy) pos_err++;
        if (int'(dx) != n_er % size || int'(dy) != n_er / size) ord_err++;
        n_er++;
      end else if (plt) begin
        if (first_dr < 0) first_dr = k;
        if (int'(x0) != ex || int'(y0) != ey || int'(col) != icol) pos_err++;
        if (int'(dx) != n_dr % size || int'(dy) != n_dr / size) ord_err++;
        if (int'(x0) + int'(dx) > mx) mx = int'(x0) + int'(dx);
        if (int'(y0) + int'(dy) > my) my = int'(y0) + int'(dy);
        n_dr++;
      end
      if (dn) begin
        done_cyc = k;
        go = 1'b0;
        break;
      end
    end
    go = 1'b0;
    if (done_cyc < 0) chk({tag, ".timeout"}, 0, 1);
    chk({tag, ".erase_cnt"}, n_er, exp_erase ? s : 0);
    chk({tag, ".draw_cnt"},  n_dr, s);
    chk({tag, ".first_draw"}, first_dr, exp_erase ? s + 2 : 2);
    chk({tag, ".done_cyc"},  done_cyc, exp_done);
    chk({tag, ".pos_err"},   pos_err, 0);
    chk({tag, ".order_err"}, ord_err, 0);
    chk({tag, ".ready_busy"}, rdy_err, 0);
    chk({tag, ".max_x"}, mx, ex + size - 1);
    chk({tag, ".max_y"}, my, ey + size - 1);
    @(negedge clk);
    chk({tag, ".ready_after"}, int'(rdy), 1);
    chk({tag, ".done_after"},  int'(dn),  0);
    @(negedge clk);
    chk({tag, ".ready_idle"},  int'(rdy), 1);
    chk({tag, ".plot_idle"},   int'(plt), 0);
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst");

    do_move("first",   10, 20, 'h3F, 1'b0, 16, 1'b0, 0, 0, 10, 20, 258);
    do_move("second",  30, 40, 'h15, 1'b0, 16, 1'b1, 10, 20, 30, 40, 514);
    do_move("same",    30, 40, 'h2A, 1'b0, 16, 1'b1, 30, 40, 30, 40, 514);
    do_move("clamp",  200, 127, 'h01, 1'b0, 16, 1'b1, 30, 40, 144, 104, 514);
    do_move("hold",     5,  6, 'h0C, 1'b1, 16, 1'b1, 144, 104, 5, 6, 514);

    // Reset at draw pixel 100 (dx=4, dy=6) of a move that also erases.
    @(negedge clk);
    nx = 8'd50; ny = 7'd50; ncol = 6'h22; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    guard = 0;
    while (!(plt && !und && dx == 4'd4 && dy == 4'd6) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("midreset.reach_px100", int'(guard < 1000), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("midreset");
    rst = 1'b0;
    do_move("after_rst", 7, 8, 'h11, 1'b0, 16, 1'b0, 0, 0, 7, 8, 258);

    // Reset and go in the same cycle: reset wins, no move starts.
    @(negedge clk);
    rst = 1'b1; go = 1'b1; nx = 8'd60; ny = 7'd60;
    @(negedge clk);
    rst = 1'b0; go = 1'b0;
    chk_reset_vals("rst_go");
    @(negedge clk);
    chk("rst_go.still_idle", int'(rdy), 1);

    // Small sprite: full scan order check.
    sel = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_move("size4", 0, 0, 'h07, 1'b0, 4, 1'b0, 0, 0, 0, 0, 18);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_draw_ctrl.md
SPRITE_DRAW_CTRL -- requirements
Module: sprite_draw_ctrl

Interface
REQ-001 The block SHALL have parameter SIZE, default 16, giving the sprite side length in pixels (legal range 1..16).
REQ-002 The block SHALL have parameter SCREEN_W, default 160, giving the screen width in pixels.
REQ-003 The block SHALL have parameter SCREEN_H, default 120, giving the screen height in pixels.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port go, input, 1 bit: move request, sampled only while ready=1.
REQ-007 The block SHALL have port new_x, input, 8 bits: requested sprite top-left x.
REQ-008 The block SHALL have port new_y, input, 7 bits: requested sprite top-left y.
REQ-009 The block SHALL have port color_in, input, 6 bits: sprite colour for this request.
REQ-010 The block SHALL have port ready, output, 1 bit: high in IDLE; a request is accepted on go=1 and ready=1.
REQ-011 The block SHALL have port x0, output, 8 bits: base x to the datapath.
REQ-012 The block SHALL have port y0, output, 7 bits: base y to the datapath.
REQ-013 The block SHALL have port dx, output, 4 bits: pixel column offset within the sprite.
REQ-014 The block SHALL have port dy, output, 4 bits: pixel row offset within the sprite.
REQ-015 The block SHALL have port color, output, 6 bits: registered colour to the datapath.
REQ-016 The block SHALL have port undraw, output, 1 bit: high during erase so the datapath forces black.
REQ-017 The block SHALL have port plot, output, 1 bit: VGA write enable, valid with x0+dx, y0+dy.
REQ-018 The block SHALL have port done, output, 1 bit: one-cycle pulse when a move completes.

Function
REQ-019 The FSM SHALL have five states: IDLE, ERASE, LOAD, DRAW and DONE.
REQ-020 In IDLE, go=1 SHALL capture new_x, new_y and color_in into pending registers, then transition to ERASE if drawn=1, else to LOAD.
REQ-021 In ERASE, plot=1 and undraw=1 SHALL be driven at the old x0/y0, scanning dx fastest and dy slowest from (0,0) to (SIZE-1,SIZE-1), one pixel per cycle; after the last pixel the FSM SHALL go to LOAD.
REQ-022 LOAD SHALL last one cycle with plot=0: x0/y0/color <= pending values; dx=dy=0; then the FSM SHALL go to DRAW.
REQ-023 In DRAW, plot=1 and undraw=0 SHALL be driven for SIZE*SIZE cycles in the same scan order; after the last pixel the FSM SHALL set drawn=1 and go to DONE.
REQ-024 DONE SHALL last one cycle with done=1, plot=0, then return to IDLE.
REQ-025 ready SHALL be 1 only in IDLE; go in any other state SHALL be ignored, not queued.
REQ-026 Latency, go accepted at cycle 0 with drawn=1: ERASE runs cycles 1..S (S=SIZE*SIZE), LOAD at S+1, DRAW at S+2..2S+1, done at 2S+2, ready again at 2S+3.
REQ-027 Latency with drawn=0: LOAD at cycle 1, DRAW at 2..S+1, done at S+2.
REQ-028 Clamping: pending x SHALL be min(new_x, SCREEN_W-SIZE) and pending y min(new_y, SCREEN_H-SIZE), compared at 8 bits unsigned so no pixel falls off-screen.
REQ-029 Counter wrap: dx=SIZE-1 SHALL wrap dx to 0 and increment dy; the last pixel is dx=dy=SIZE-1; dx/dy SHALL hold 0 outside ERASE and DRAW.
REQ-030 A request equal to the current position SHALL still perform full erase and redraw.

Reset
REQ-031 Reset SHALL set the state to IDLE, ready=1, plot=0, undraw=0, done=0, x0=0, y0=0, dx=0, dy=0, color=0, drawn=0 and clear the pending registers.
REQ-032 Reset mid-ERASE or mid-DRAW SHALL drop plot on the next clock edge, with no cleanup of the partially written pixels, and the first go after reset SHALL skip ERASE.
REQ-033 Reset SHALL take priority over go in the same cycle.

Structure
REQ-034 Package sprite_pkg SHALL hold the state enum and the SCREEN_W/SCREEN_H defaults.
REQ-035 One sub-module, pixel_scan_counter, SHALL be used: clear and enable inputs; dx, dy and last outputs; instantiated once and shared by ERASE and DRAW.

Verification
REQ-036 After reset, go with new_x=10, new_y=20, color=6'h3F SHALL give no ERASE, 256 plot cycles at x0=10/y0=20 with undraw=0, and done at cycle 258.
REQ-037 A second go to (30,40) SHALL give 256 undraw plots at (10,20), a LOAD gap, then 256 plots at (30,40), with done at cycle 514.
REQ-038 Clamp: new_x=200, new_y=127 SHALL give x0=144, y0=104; the maximum plotted pixel SHALL be (159,119).
REQ-039 go held high during DRAW SHALL produce exactly one move, with ready=0 throughout and ready=1 the cycle after done.
REQ-040 reset asserted at DRAW pixel 100 SHALL give plot=0 next cycle with outputs at reset values, and the next go SHALL go straight to LOAD.
REQ-041 SIZE=4 with go to (0,0) SHALL give 16 plots ordered (0,0),(1,0),...,(3,3) and done at cycle 18.
